overlay_iq_scheduler: RTL and testbench
=======================================

// Module: overlay_iq_scheduler
// PURPOSE
//  Time-multiplexes the two receive IQ streams (ch0 = I0/Q0, ch1 = I1/Q1) onto one
//  shared overlay processing datapath. Buffers each channel in a small FIFO.
//  Arbitrates with bursted round-robin or fixed modes. Presents a registered
//  valid/ready output tagged with the channel ID. Sits between the AD936x sample
//  interface and the shared overlay DSP core.
// PARAMETERS
//  DATA_W     16  width of each I and Q sample (signed)
//  FIFO_DEPTH  8  per-channel FIFO depth, power of two, >= 2
//  BURST_W     4  width of i_burst_len and of the burst counter
//  CNT_W      16  width of the drop counters (SCHED_STATS_EN only)
// PORTS
//  i_clk          in   1         system clock; all logic on the rising edge
//  i_rst_n        in   1         asynchronous, active-low reset
//  i_enable       in   1         0: no pushes accepted, FIFOs flushed, arbiter held in IDLE
//  i_mode         in   2         00 round-robin, 01 ch0 only, 10 ch1 only, 11 ch0 strict priority
//  i_burst_len    in   BURST_W   grants per turn in round-robin; 0 is treated as 1
//  i_I0_data      in   DATA_W    ch0 I sample
//  i_Q0_data      in   DATA_W    ch0 Q sample
//  i_I1_data      in   DATA_W    ch1 I sample
//  i_Q1_data      in   DATA_W    ch1 Q sample
//  i_I0_valid     in   1         ch0 strobe; I and Q valids are ANDed per channel
//  i_Q0_valid     in   1         ch0 strobe (Q)
//  i_I1_valid     in   1         ch1 strobe (I)
//  i_Q1_valid     in   1         ch1 strobe (Q)
//  o_I_data       out  DATA_W    granted I sample
//  o_Q_data       out  DATA_W    granted Q sample
//  o_chan         out  1         channel of the current output word
//  o_valid        out  1         output word valid
//  i_ready        in   1         shared datapath accepts the word when o_valid && i_ready
//  o_ovf          out  2         sticky per-channel overflow flags
//  i_ovf_clr      in   1         one-cycle pulse; clears o_ovf (a set in the same cycle wins)
// BEHAVIOUR
//  Reset: FIFOs empty, FSM in IDLE, rr pointer = ch0, burst counter = 0.
//   All outputs read 0.
//  Push: a word is written when both valids are high, i_enable = 1, and the FIFO is
//   not full. A pop in the same cycle frees a slot, so push and pop together on a
//   full FIFO is accepted. Otherwise the sample is dropped and o_ovf[ch] is set.
//  Output register: loads when o_valid = 0 or i_ready = 1 and the FSM grants a
//   non-empty FIFO. o_I_data, o_Q_data and o_chan are held stable while
//   o_valid && !i_ready. Latency is 2 cycles: strobe at edge k, o_valid high after
//   edge k+1. Throughput is 1 word/cycle.
//  FSM states:
//   IDLE -> GRANT0 or GRANT1 when an eligible FIFO is non-empty.
//   In GRANTx, each load from chx increments the burst counter.
//   Leave GRANTx to the other channel when (burst counter == max(burst_len,1) or
//    chx is empty) and the other channel is non-empty. Reset the counter on switch.
//   Stay in GRANTx if the other channel is empty.
//   Go to IDLE when both FIFOs are empty.
//  Modes 01/10: the other FIFO still fills and overflows but is never granted.
//  Mode 11: GRANT1 only while ch0 is empty. Preempt back to ch0 on the next load
//   after ch0 becomes non-empty.
//  Mode or burst change takes effect at the next grant decision. The word in the
//   output register is never discarded.
//  i_enable falling: FIFOs flush on the next edge. The word in the output register
//   stays valid until accepted; the FSM then returns to IDLE.
// CONFIGURATION
//  SCHED_STATS_EN defined: adds o_drop0_cnt and o_drop1_cnt (CNT_W, outputs).
//   Each counts dropped samples, saturates at all-ones, and is cleared by i_ovf_clr.
//  SCHED_STATS_EN undefined: these ports and counters are absent; o_ovf is unchanged.
// STRUCTURE
//  overlay_pkg holds the mode encodings (MODE_RR, MODE_CH0, MODE_CH1, MODE_PRIO0),
//   the FSM state typedef, and the channel-ID constants.
//  One sub-module, iq_sync_fifo: parameterised depth and width, push/pop/full/empty,
//   and a synchronous flush. It is instantiated once per channel with a width of
//   2*DATA_W.
// TESTING
//  - Reset mid-stream: hold i_rst_n low with both FIFOs holding 3 words ->
//     o_valid, o_ovf and the FIFO counts are 0 immediately, without waiting for
//     a clock edge.
//  - RR burst_len = 2, both channels strobing every cycle, i_ready = 1 ->
//     o_chan = 0,0,1,1,0,0,...; no word lost or duplicated.
//  - Mode 01, ch1 strobed 9 times with FIFO_DEPTH = 8 -> no ch1 output;
//     o_ovf = 2'b10; with SCHED_STATS_EN, o_drop1_cnt = 1.
//  - Backpressure: i_ready = 0 for 5 cycles with ch0 word 0x1234/0x8000 ->
//     output held bit-stable; accepted on the first i_ready = 1.
//  - Mode 11, ch1 bursting, ch0 strobed once -> ch0 word is the next word loaded
//     after ch0 becomes non-empty, then ch1 resumes.
//  - i_ovf_clr coincident with an overflow on ch0 -> o_ovf[0] stays 1.

Source files
------------

// File: rtl/overlay_pkg.sv
// Shared definitions for the overlay IQ scheduler: mode encodings, channel IDs and the
// arbiter state type.
package overlay_pkg;

  // i_mode encodings
  localparam logic [1:0] MODE_RR    = 2'b00;
  localparam logic [1:0] MODE_CH0   = 2'b01;
  localparam logic [1:0] MODE_CH1   = 2'b10;
  localparam logic [1:0] MODE_PRIO0 = 2'b11;

  // Channel IDs as presented on o_chan
  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StGrant0,
    StGrant1
  } sched_state_e;

endpackage

// File: rtl/iq_sync_fifo.sv
// Single-clock FIFO with a combinational read port and a synchronous flush.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   flush_i       : empties the FIFO on the next edge (wins over push/pop)
//   push_i/wdata_i: write request; accepted when not full or when popping in the same cycle
//   pop_i/rdata_o : rdata_o shows the head word; pop_i advances past it
//   full_o/empty_o: occupancy flags
module iq_sync_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = AddrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             wr_en, rd_en;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  assign rd_en = pop_i & ~empty_o;
  assign wr_en = push_i & (~full_o | rd_en);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + AddrW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + AddrW'(1);
      unique case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/overlay_iq_scheduler.sv
// Time-multiplexes two IQ receive channels onto one shared datapath.
// Each channel is buffered in an iq_sync_fifo; an arbiter (bursted round-robin, single
// channel, or ch0 strict priority) chooses which FIFO feeds the registered output stage.
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_enable                : 0 flushes both FIFOs and parks the arbiter
//   i_mode, i_burst_len     : arbitration mode and round-robin burst length (0 acts as 1)
//   i_{I,Q}{0,1}_data/valid : channel samples; a sample needs both its I and Q strobe
//   o_I_data, o_Q_data,
//   o_chan, o_valid, i_ready: registered output word with valid/ready handshake
//   o_ovf, i_ovf_clr        : sticky per-channel overflow flags and their clear pulse
// Optional feature macro SCHED_STATS_EN adds saturating drop counters o_drop0_cnt and
// o_drop1_cnt, also cleared by i_ovf_clr.
module overlay_iq_scheduler
  import overlay_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FIFO_DEPTH = 8,
`ifdef SCHED_STATS_EN
  parameter int unsigned CNT_W      = 16,
`endif
  parameter int unsigned BURST_W    = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic [1:0]        i_mode,
  input  logic [BURST_W-1:0] i_burst_len,
  input  logic [DATA_W-1:0] i_I0_data,
  input  logic [DATA_W-1:0] i_Q0_data,
  input  logic [DATA_W-1:0] i_I1_data,
  input  logic [DATA_W-1:0] i_Q1_data,
  input  logic              i_I0_valid,
  input  logic              i_Q0_valid,
  input  logic              i_I1_valid,
  input  logic              i_Q1_valid,
  output logic [DATA_W-1:0] o_I_data,
  output logic [DATA_W-1:0] o_Q_data,
  output logic              o_chan,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [1:0]        o_ovf,
  input  logic              i_ovf_clr
`ifdef SCHED_STATS_EN
  ,
  output logic [CNT_W-1:0]  o_drop0_cnt,
  output logic [CNT_W-1:0]  o_drop1_cnt
`endif
);

  localparam int unsigned WordW = 2 * DATA_W;

  sched_state_e       state_q, state_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d, burst_eff;
  logic               rr_q, rr_d;
  logic               out_valid_q, out_valid_d, out_chan_q, out_chan_d;
  logic [DATA_W-1:0]  out_i_q, out_i_d, out_q_q, out_q_d;
  logic [1:0]         ovf_q, ovf_d;

  logic [WordW-1:0]   rdata0, rdata1;
  logic               full0, full1, empty0, empty1;
  logic               fire0, fire1, push0, push1, pop0, pop1, drop0, drop1;
  logic               elig0, elig1, cur, mine, other, leave, sel, load;

  assign fire0 = i_I0_valid & i_Q0_valid;
  assign fire1 = i_I1_valid & i_Q1_valid;

  // Grant decision is combinational so a word strobed at edge k can load at edge k+1.
  always_comb begin
    elig0     = ~empty0 & (i_mode != MODE_CH1);
    elig1     = ~empty1 & (i_mode != MODE_CH0);
    cur       = (state_q == StGrant1);
    mine      = cur ? elig1 : elig0;
    other     = cur ? elig0 : elig1;
    burst_eff = (i_burst_len == '0) ? BURST_W'(1) : i_burst_len;
    leave     = 1'b0;
    sel       = CH0;
    if (state_q == StIdle) begin
      // From idle, priority mode always prefers ch0; round-robin resumes at rr_q.
      sel = (i_mode == MODE_PRIO0) ? CH0 : rr_q;
      if (!(sel ? elig1 : elig0)) sel = ~sel;
    end else begin
      if (i_mode == MODE_PRIO0) leave = cur ? 1'b1 : ~mine;
      else                      leave = ~mine | (burst_cnt_q >= burst_eff);
      if (leave && other) sel = ~cur;
      else if (mine)      sel = cur;
      else                sel = ~cur;
    end
    load = i_enable & (~out_valid_q | i_ready) & (elig0 | elig1);
    pop0 = load & (sel == CH0);
    pop1 = load & (sel == CH1);
  end

  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push0 = fire0 & i_enable & (~full0 | pop0);
  assign push1 = fire1 & i_enable & (~full1 | pop1);
  assign drop0 = fire0 & i_enable & full0 & ~pop0;
  assign drop1 = fire1 & i_enable & full1 & ~pop1;

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    rr_d        = rr_q;
    out_valid_d = out_valid_q & ~i_ready;
    out_chan_d  = out_chan_q;
    out_i_d     = out_i_q;
    out_q_d     = out_q_q;
    // A set in the same cycle as the clear wins.
    ovf_d       = (ovf_q & ~{2{i_ovf_clr}}) | {drop1, drop0};

    if (!i_enable) begin
      state_d     = StIdle;
      burst_cnt_d = '0;
    end else if (load) begin
      state_d = sel ? StGrant1 : StGrant0;
      rr_d    = ~sel;
      if ((state_q != StIdle) && (sel == cur)) begin
        if (burst_cnt_q != '1) burst_cnt_d = burst_cnt_q + BURST_W'(1);
      end else begin
        burst_cnt_d = BURST_W'(1);
      end
    end else if (!(elig0 | elig1)) begin
      state_d     = StIdle;
      burst_cnt_d = '0;
    end

    if (load) begin
      out_valid_d = 1'b1;
      out_chan_d  = sel;
      {out_i_d, out_q_d} = sel ? rdata1 : rdata0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      burst_cnt_q <= '0;
      rr_q        <= CH0;
      out_valid_q <= 1'b0;
      out_chan_q  <= CH0;
      out_i_q     <= '0;
      out_q_q     <= '0;
      ovf_q       <= '0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      rr_q        <= rr_d;
      out_valid_q <= out_valid_d;
      out_chan_q  <= out_chan_d;
      out_i_q     <= out_i_d;
      out_q_q     <= out_q_d;
      ovf_q       <= ovf_d;
    end
  end

  assign o_valid  = out_valid_q;
  assign o_chan   = out_chan_q;
  assign o_I_data = out_i_q;
  assign o_Q_data = out_q_q;
  assign o_ovf    = ovf_q;

  iq_sync_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (WordW)
  ) u_fifo0 (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .flush_i (~i_enable),
    .push_i  (push0),
    .wdata_i ({i_I0_data, i_Q0_data}),
    .pop_i   (pop0),
    .rdata_o (rdata0),
    .full_o  (full0),
    .empty_o (empty0)
  );

  iq_sync_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (WordW)
  ) u_fifo1 (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .flush_i (~i_enable),
    .push_i  (push1),
    .wdata_i ({i_I1_data, i_Q1_data}),
    .pop_i   (pop1),
    .rdata_o (rdata1),
    .full_o  (full1),
    .empty_o (empty1)
  );

`ifdef SCHED_STATS_EN
  logic [CNT_W-1:0] drop0_cnt_q, drop0_cnt_d, drop1_cnt_q, drop1_cnt_d;

  // Clear first, then count this cycle's drop, saturating at all-ones.
  always_comb begin
    drop0_cnt_d = i_ovf_clr ? '0 : drop0_cnt_q;
    drop1_cnt_d = i_ovf_clr ? '0 : drop1_cnt_q;
    if (drop0 && (drop0_cnt_d != '1)) drop0_cnt_d = drop0_cnt_d + CNT_W'(1);
    if (drop1 && (drop1_cnt_d != '1)) drop1_cnt_d = drop1_cnt_d + CNT_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      drop0_cnt_q <= '0;
      drop1_cnt_q <= '0;
    end else begin
      drop0_cnt_q <= drop0_cnt_d;
      drop1_cnt_q <= drop1_cnt_d;
    end
  end

  assign o_drop0_cnt = drop0_cnt_q;
  assign o_drop1_cnt = drop1_cnt_q;
`endif

endmodule

// File: tb/tb_overlay_iq_scheduler.sv
module tb_overlay_iq_scheduler;
  import overlay_pkg::*;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned BURST_W    = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               i_enable;
  logic [1:0]         i_mode;
  logic [BURST_W-1:0] i_burst_len;
  logic [DATA_W-1:0]  i_I0_data, i_Q0_data, i_I1_data, i_Q1_data;
  logic               i_I0_valid, i_Q0_valid, i_I1_valid, i_Q1_valid;
  logic [DATA_W-1:0]  o_I_data, o_Q_data;
  logic               o_chan, o_valid, i_ready;
  logic [1:0]         o_ovf;
  logic               i_ovf_clr;
`ifdef SCHED_STATS_EN
  logic [15:0]        o_drop0_cnt, o_drop1_cnt;
`endif

  always #5 clk = ~clk;

  overlay_iq_scheduler dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_enable    (i_enable),
    .i_mode      (i_mode),
    .i_burst_len (i_burst_len),
    .i_I0_data   (i_I0_data),
    .i_Q0_data   (i_Q0_data),
    .i_I1_data   (i_I1_data),
    .i_Q1_data   (i_Q1_data),
    .i_I0_valid  (i_I0_valid),
    .i_Q0_valid  (i_Q0_valid),
    .i_I1_valid  (i_I1_valid),
    .i_Q1_valid  (i_Q1_valid),
    .o_I_data    (o_I_data),
    .o_Q_data    (o_Q_data),
    .o_chan      (o_chan),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_ovf       (o_ovf),
    .i_ovf_clr   (i_ovf_clr)
`ifdef SCHED_STATS_EN
    ,
    .o_drop0_cnt (o_drop0_cnt),
    .o_drop1_cnt (o_drop1_cnt)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: per-channel FIFO order of words the bench expects to see accepted,
  // plus an optional expected channel sequence for directed arbitration tests.
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic        exp_chan[$];
  logic [31:0] mon_word;
  logic [31:0] held_word;
  bit          mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
  endtask

  // Monitor: the word seen with o_valid && i_ready at the falling edge is accepted next edge.
  always @(negedge clk) begin
    if (mon_en && rst_n && o_valid && i_ready) begin
      mon_word = {o_I_data, o_Q_data};
      if (o_chan == CH0) begin
        chk("ch0_expected", 64'(exp_q0.size() != 0), 64'd1);
        if (exp_q0.size() != 0) chk("ch0_data", 64'(mon_word), 64'(exp_q0.pop_front()));
      end else begin
        chk("ch1_expected", 64'(exp_q1.size() != 0), 64'd1);
        if (exp_q1.size() != 0) chk("ch1_data", 64'(mon_word), 64'(exp_q1.pop_front()));
      end
      if (exp_chan.size() != 0) chk("chan_order", 64'(o_chan), 64'(exp_chan.pop_front()));
    end
  end

  // Applies one cycle of stimulus, sampled by the DUT on the following rising edge.
  task automatic step(input bit s0, input bit s1, input logic [31:0] w0,
                      input logic [31:0] w1, input bit rec, input bit clr);
    @(posedge clk);
    #1;
    {i_I0_data, i_Q0_data} = w0;
    {i_I1_data, i_Q1_data} = w1;
    i_I0_valid = s0;
    i_Q0_valid = s0;
    i_I1_valid = s1;
    i_Q1_valid = s1;
    i_ovf_clr  = clr;
    if (rec && s0) exp_q0.push_back(w0);
    if (rec && s1) exp_q1.push_back(w1);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic flush();
    @(posedge clk);
    #1;
    i_enable = 1'b0;
    @(posedge clk);
    #1;
    i_enable = 1'b1;
  endtask

  task automatic drain(input string name);
    bit done;
    done    = 1'b0;
    i_ready = 1'b1;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (exp_q0.size() == 0 && exp_q1.size() == 0 && !o_valid) done = 1'b1;
    end
    chk(name, 64'(done), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; i_enable = 1'b1; i_mode = MODE_RR; i_burst_len = 4'd1; i_ready = 1'b1;
    i_ovf_clr = 1'b0;
    {i_I0_valid, i_Q0_valid, i_I1_valid, i_Q1_valid} = 4'b0;
    {i_I0_data, i_Q0_data, i_I1_data, i_Q1_data} = '0;
    repeat (3) @(negedge clk);
    chk("reset_valid", 64'(o_valid), 64'd0);
    chk("reset_ovf", 64'(o_ovf), 64'd0);
    chk("reset_data", 64'({o_I_data, o_Q_data, o_chan}), 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    mon_en = 1'b1;

    // Round-robin, burst 2, both channels strobing; also covers the 2-cycle latency.
    i_burst_len = 4'd2;
    exp_chan = '{CH0, CH0, CH1, CH1, CH0, CH0, CH1, CH1};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i), 1'b1, 1'b0);
      @(negedge clk);
      if (i == 1) chk("latency_edge_k", 64'(o_valid), 64'd0);
      if (i == 2) chk("latency_edge_k1", 64'(o_valid), 64'd1);
    end
    idle();
    drain("rr_drain");
    chk("rr_chan_consumed", 64'(exp_chan.size()), 64'd0);

    // Backpressure: word held bit-stable for 5 cycles, taken on the first ready.
    i_ready = 1'b0;
    step(1'b1, 1'b0, 32'h1234_8000, 32'h0, 1'b1, 1'b0);
    idle();
    @(negedge clk);
    held_word = 32'h1234_8000;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_hold", 64'({o_valid, o_chan, o_I_data, o_Q_data}), 64'({1'b1, CH0, held_word}));
    end
    @(posedge clk); #1; i_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_accepted_once", 64'(o_valid), 64'd0);
    chk("bp_consumed", 64'(exp_q0.size()), 64'd0);

    // Ch0 strict priority: ch0 word preempts a ch1 burst at the next load.
    i_mode = MODE_PRIO0;
    exp_chan = '{CH1, CH1, CH0, CH1, CH1, CH1, CH1};
    for (int i = 0; i < 6; i++)
      step(i == 2, 1'b1, 32'hC0C0_0000 + 32'(i), 32'hD1D1_0000 + 32'(i), 1'b1, 1'b0);
    idle();
    drain("prio_drain");
    chk("prio_chan_consumed", 64'(exp_chan.size()), 64'd0);

    // Mode 01: ch1 fills and overflows on the 9th strobe but is never output.
    i_mode = MODE_CH0;
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 32'h0, 32'hEE00_0000 + 32'(i), 1'b0, 1'b0);
    idle();
    repeat (3) @(negedge clk);
    chk("ch0only_no_output", 64'(o_valid), 64'd0);
    chk("ch0only_ovf", 64'(o_ovf), 64'b10);
`ifdef SCHED_STATS_EN
    chk("ch0only_drop1", 64'(o_drop1_cnt), 64'd1);
`endif
    flush();
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    idle();
    @(negedge clk);
    chk("ovf_clear", 64'(o_ovf), 64'd0);
    // Flushed ch1 must have nothing left to grant.
    i_mode = MODE_CH1;
    repeat (3) @(negedge clk);
    chk("flush_empty", 64'(o_valid), 64'd0);

    // Clear coincident with a ch0 overflow: the set wins.
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 32'h5500_0000 + 32'(i), 32'h0, 1'b0, i == 8);
    idle();
    @(negedge clk);
    chk("ovf_set_wins", 64'(o_ovf), 64'b01);
    flush();
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    idle();

    // Randomized traffic in round-robin and priority modes, never overflowing.
    for (int c = 0; c < 600; c++) begin
      bit s0, s1;
      if (c % 60 == 0) begin
        i_mode      = ($urandom_range(0, 1) != 0) ? MODE_PRIO0 : MODE_RR;
        i_burst_len = 4'($urandom_range(0, 3));
      end
      s0 = (exp_q0.size() < FIFO_DEPTH) && ($urandom_range(0, 2) != 0);
      s1 = (exp_q1.size() < FIFO_DEPTH) && ($urandom_range(0, 2) != 0);
      step(s0, s1, $urandom, $urandom, 1'b1, 1'b0);
      i_ready = ($urandom_range(0, 3) != 0);
    end
    idle();
    drain("rand_drain");
    chk("rand_no_ovf", 64'(o_ovf), 64'd0);

    // Reset mid-stream with 3 words in each FIFO and a word held at the output.
    i_mode = MODE_RR; i_burst_len = 4'd1; i_ready = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, i < 3, 32'h7700_0000 + 32'(i),
                                     32'h8800_0000 + 32'(i), 1'b0, 1'b0);
    idle();
    @(negedge clk);
    chk("pre_reset_cnt0", 64'(dut.u_fifo0.count_q), 64'd3);
    chk("pre_reset_cnt1", 64'(dut.u_fifo1.count_q), 64'd3);
    chk("pre_reset_valid", 64'(o_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", 64'(o_valid), 64'd0);
    chk("async_reset_ovf", 64'(o_ovf), 64'd0);
    chk("async_reset_cnt0", 64'(dut.u_fifo0.count_q), 64'd0);
    chk("async_reset_cnt1", 64'(dut.u_fifo1.count_q), 64'd0);
    @(posedge clk); #1; rst_n = 1'b1; i_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_idle", 64'(o_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
